// File: rtl/traffic_phase_controller.sv
// Four-way intersection phase sequencer: owns the WWSSEENN light bus and steps
// RED_A -> EW_G -> EW_Y -> RED_B -> NS_G -> NS_Y on per-state 8-bit timers.
module traffic_phase_controller #(
   parameter int GREEN_EW       = 8,
   parameter int GREEN_NS       = 8,
   parameter int NIGHT_NS_GREEN = 4,
   parameter int YELLOW         = 3,
   parameter int ALLRED         = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       night,
   input  logic       nsRequest,
   output logic [7:0] laneOutput,
   output logic [2:0] phase,
   output logic       cycleStart
);

   localparam logic [2:0] RED_A = 3'd0;
   localparam logic [2:0] EW_G  = 3'd1;
   localparam logic [2:0] EW_Y  = 3'd2;
   localparam logic [2:0] RED_B = 3'd3;
   localparam logic [2:0] NS_G  = 3'd4;
   localparam logic [2:0] NS_Y  = 3'd5;

   localparam logic [7:0] L_GREEN_EW = 8'(GREEN_EW - 1);
   localparam logic [7:0] L_GREEN_NS = 8'(GREEN_NS - 1);
   localparam logic [7:0] L_NIGHT_NS = 8'(NIGHT_NS_GREEN - 1);
   localparam logic [7:0] L_YELLOW   = 8'(YELLOW - 1);
   localparam logic [7:0] L_ALLRED   = 8'(ALLRED - 1);

   logic [2:0] r_state;
   logic [7:0] r_timer;
   logic       r_pending;
   logic [7:0] r_lane;
   logic       r_cycle_start;

   logic [2:0] w_next_state;
   logic [7:0] w_next_timer;
   logic       w_timer_done;
   logic       w_req_seen;
   logic       w_enter_ns;

   function automatic logic [7:0] lights_for(input logic [2:0] s);
      case (s)
         EW_G:    lights_for = 8'b11001100;
         EW_Y:    lights_for = 8'b01000100;
         NS_G:    lights_for = 8'b00110011;
         NS_Y:    lights_for = 8'b00010001;
         default: lights_for = 8'b00000000;
      endcase
   endfunction

   // A request on the same cycle as the expired night minimum releases EW_G at once.
   assign w_timer_done = (r_timer == 8'd0);
   assign w_req_seen   = r_pending | nsRequest;
   assign w_enter_ns   = (w_next_state == NS_G) && (r_state != NS_G);

   always_comb begin
      w_next_state = r_state;
      w_next_timer = r_timer;
      case (r_state)
         RED_A: begin
            if (w_timer_done) begin
               w_next_state = EW_G;
               w_next_timer = L_GREEN_EW;
            end else begin
               w_next_timer = r_timer - 8'd1;
            end
         end
         EW_G: begin
            if (w_timer_done) begin
               if (!night || w_req_seen) begin
                  w_next_state = EW_Y;
                  w_next_timer = L_YELLOW;
               end
            end else begin
               w_next_timer = r_timer - 8'd1;
            end
         end
         EW_Y: begin
            if (w_timer_done) begin
               w_next_state = RED_B;
               w_next_timer = L_ALLRED;
            end else begin
               w_next_timer = r_timer - 8'd1;
            end
         end
         RED_B: begin
            if (w_timer_done) begin
               w_next_state = NS_G;
               w_next_timer = night ? L_NIGHT_NS : L_GREEN_NS;
            end else begin
               w_next_timer = r_timer - 8'd1;
            end
         end
         NS_G: begin
            if (w_timer_done) begin
               w_next_state = NS_Y;
               w_next_timer = L_YELLOW;
            end else begin
               w_next_timer = r_timer - 8'd1;
            end
         end
         NS_Y: begin
            if (w_timer_done) begin
               w_next_state = RED_A;
               w_next_timer = L_ALLRED;
            end else begin
               w_next_timer = r_timer - 8'd1;
            end
         end
         default: begin
            w_next_state = RED_A;
            w_next_timer = L_ALLRED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= RED_A;
         r_timer       <= L_ALLRED;
         r_pending     <= 1'b0;
         r_lane        <= 8'b00000000;
         r_cycle_start <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_timer       <= w_next_timer;
         r_lane        <= lights_for(w_next_state);
         r_cycle_start <= (w_next_state == EW_G) && (r_state != EW_G);
         // Entering NS_G serves the request, so clearing beats a same-cycle set.
         if (w_enter_ns) begin
            r_pending <= 1'b0;
         end else if (nsRequest && (r_state != NS_G)) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign laneOutput = r_lane;
   assign phase      = r_state;
   assign cycleStart = r_cycle_start;

endmodule
